// File: rtl/tc_ram_arbiter_if.sv
// tc_ram_arbiter_if
// Requester-side bus of the two-port RAM arbiter. Carries both requesters'
// op valid/type/address/write data and their grant and tagged read response.
//   a_req/b_req       requester op valid
//   a_we/b_we         1 = write, 0 = read
//   a_addr/b_addr     word address
//   a_wdata/b_wdata   write data
//   a_gnt/b_gnt       op accepted this cycle (combinational from arbiter)
//   a_rvalid/b_rvalid read data valid, single-cycle pulse
//   a_rdata/b_rdata   read data, holds between pulses
// Modports: master = requester side, slave = arbiter side.
interface tc_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/tc_ram_arbiter.sv
// tc_ram_arbiter
// Round-robin arbiter and sequencer in front of a single TC_Ram
// (registered read, negedge write). Two requesters share the RAM through a
// valid/grant handshake; read data comes back two edges after the handshake
// on the issuing requester's response outputs. After reset the RAM can be
// swept to CLEAR_VALUE, because the RAM's own reset only clears the word
// currently addressed.
// Ports:
//   clk            clock, all state changes on posedge
//   rst            asynchronous active-high reset
//   io_bus         requester bus (slave side), see tc_ram_arbiter_if
//   o_busy         high while the clear sweep runs
//   o_ram_load     RAM load (read strobe)
//   o_ram_save     RAM save (write strobe)
//   o_ram_address  RAM address
//   o_ram_in       RAM write data
//   i_ram_out      RAM registered read data
module tc_ram_arbiter #(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 8,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic               clk,
  input  logic               rst,
  tc_ram_arbiter_if.slave    io_bus,
  output logic               o_busy,
  output logic               o_ram_load,
  output logic               o_ram_save,
  output logic [ADDR_W-1:0]  o_ram_address,
  output logic [DATA_W-1:0]  o_ram_in,
  input  logic [DATA_W-1:0]  i_ram_out
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic              RESET_BUSY  = (CLEAR_ON_RESET != 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  state_t            r_state;
  logic              r_busy;
  logic [ADDR_W-1:0] r_clearCnt;
  logic              r_ptrB;
  logic              r_ramLoad;
  logic              r_ramSave;
  logic [ADDR_W-1:0] r_ramAddress;
  logic [DATA_W-1:0] r_ramIn;

  logic              r_s1Valid;
  logic              r_s1IdB;
  logic              r_s2Valid;
  logic              r_s2IdB;
  logic              r_aRvalid;
  logic              r_bRvalid;
  logic [DATA_W-1:0] r_aRdata;
  logic [DATA_W-1:0] r_bRdata;

  logic              w_run;
  logic              w_aGnt;
  logic              w_bGnt;
  logic              w_xfer;
  logic              w_xferWe;
  logic [ADDR_W-1:0] w_xferAddr;
  logic [DATA_W-1:0] w_xferData;

  // Grant: a lone requester always wins; on contention the priority
  // pointer (0 = A, 1 = B) picks the winner. No grants during the sweep.
  // The winner's op fields are muxed here so the issue logic sees one op.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_aGnt     = w_run && io_bus.a_req && (!io_bus.b_req || !r_ptrB);
    w_bGnt     = w_run && io_bus.b_req && (!io_bus.a_req ||  r_ptrB);
    w_xfer     = w_aGnt || w_bGnt;
    w_xferWe   = io_bus.a_we;
    w_xferAddr = io_bus.a_addr;
    w_xferData = io_bus.a_wdata;
    if (w_bGnt) begin
      w_xferWe   = io_bus.b_we;
      w_xferAddr = io_bus.b_addr;
      w_xferData = io_bus.b_wdata;
    end
  end

  // Control FSM. CLEAR issues one save per cycle over the whole address
  // range and then hands over to RUN for good. RUN registers the winning
  // op onto the RAM pins; idle cycles drop the strobes but keep address
  // and data. The pointer flips to the loser after every transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RESET_STATE;
      r_busy       <= RESET_BUSY;
      r_clearCnt   <= '0;
      r_ptrB       <= 1'b0;
      r_ramLoad    <= 1'b0;
      r_ramSave    <= 1'b0;
      r_ramAddress <= '0;
      r_ramIn      <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ramSave    <= 1'b1;
          r_ramLoad    <= 1'b0;
          r_ramAddress <= r_clearCnt;
          r_ramIn      <= CLEAR_VALUE;
          r_clearCnt   <= r_clearCnt + 1'b1;
          if (r_clearCnt == LAST_ADDR) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_ramLoad <= w_xfer && !w_xferWe;
          r_ramSave <= w_xfer &&  w_xferWe;
          if (w_xfer) begin
            r_ramAddress <= w_xferAddr;
            r_ramIn      <= w_xferData;
            r_ptrB       <= w_aGnt;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Read return path. Stage 1 lines up with the cycle the load strobe is on
  // the RAM pins; stage 2 with the cycle the RAM's registered output holds
  // the word; the next edge captures it into the issuer's rdata and raises
  // that issuer's rvalid for one cycle. Reset flushes anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1IdB   <= 1'b0;
      r_s2Valid <= 1'b0;
      r_s2IdB   <= 1'b0;
      r_aRvalid <= 1'b0;
      r_bRvalid <= 1'b0;
      r_aRdata  <= '0;
      r_bRdata  <= '0;
    end else begin
      r_s1Valid <= w_xfer && !w_xferWe;
      r_s1IdB   <= w_bGnt;
      r_s2Valid <= r_s1Valid;
      r_s2IdB   <= r_s1IdB;
      r_aRvalid <= r_s2Valid && !r_s2IdB;
      r_bRvalid <= r_s2Valid &&  r_s2IdB;
      if (r_s2Valid && !r_s2IdB) begin
        r_aRdata <= i_ram_out;
      end
      if (r_s2Valid && r_s2IdB) begin
        r_bRdata <= i_ram_out;
      end
    end
  end

  assign io_bus.a_gnt    = w_aGnt;
  assign io_bus.b_gnt    = w_bGnt;
  assign io_bus.a_rvalid = r_aRvalid;
  assign io_bus.b_rvalid = r_bRvalid;
  assign io_bus.a_rdata  = r_aRdata;
  assign io_bus.b_rdata  = r_bRdata;

  assign o_busy        = r_busy;
  assign o_ram_load    = r_ramLoad;
  assign o_ram_save    = r_ramSave;
  assign o_ram_address = r_ramAddress;
  assign o_ram_in      = r_ramIn;

endmodule

// File: doc/tc_ram_arbiter.md
Name: tc_ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of a single TC_Ram instance (256 x 8, registered read, negedge write).
- Gives requesters A and B a valid/ready interface, drives the RAM's load/save/address/in from registers, and returns read data tagged to the issuing requester.
- Optionally sweeps the RAM to a known value after reset, because the RAM's own reset clears only the currently addressed word.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, data width.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN.
- CLEAR_VALUE, 0, word written by the clear sweep.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A op valid.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid, 1-cycle pulse.
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- busy  out  1  high while the clear sweep runs.
- ram_load  out  1  to RAM load.
- ram_save  out  1  to RAM save.
- ram_address  out  ADDR_W  to RAM address.
- ram_in  out  DATA_W  to RAM in.
- ram_out  in  DATA_W  from RAM out.

Behaviour:
- Reset (async, rst=1) values:
  - Outputs: ram_load, ram_save, ram_address, ram_in, a/b_rvalid, a/b_rdata = 0.
  - Internal: priority pointer = A; read pipeline cleared.
  - State: busy = CLEAR_ON_RESET; state = CLEAR if CLEAR_ON_RESET, else RUN; clear counter = 0.
- FSM states: CLEAR, RUN.
  - CLEAR, each cycle:
    - ram_save=1, ram_load=0, ram_address=counter, ram_in=CLEAR_VALUE; counter increments.
    - After address 2**ADDR_W-1 is issued, next state is RUN and busy drops.
    - The sweep takes exactly 2**ADDR_W cycles of ram_save high.
    - a_gnt and b_gnt are 0 throughout.
  - RUN: arbitrates every cycle; never leaves RUN except via rst.
- Grant (RUN only, combinational):
  - Only one requester asserting req: it wins.
  - Both asserting: the requester named by the priority pointer wins.
  - Winner's gnt = 1; loser's gnt = 0.
  - Transfer occurs at the posedge where req && gnt.
  - After a transfer the pointer moves to the other requester. No transfer: pointer holds.
  - Consequence: with both requesters continuously requesting, grants alternate strictly A, B, A, B…
- Issue (registered):
  - On a transfer, the cycle after the edge has:
    - ram_address = winner addr;
    - ram_in = winner wdata;
    - ram_save = we;
    - ram_load = !we.
  - Cycles with no transfer: ram_load = ram_save = 0; ram_address and ram_in hold their last values.
  - ram_load and ram_save are never both 1.
- Throughput: one op per cycle, back-to-back, any read/write mix.
- Read pipeline:
  - Handshake at edge P0; RAM captures its output at P1; arbiter registers ram_out into x_rdata at P2.
  - x_rvalid is high for the single cycle following P2.
  - Read latency = 2 edges after the handshake edge.
  - An issuer-ID tag travels with the op and selects a_ or b_ outputs.
  - rdata holds its value when rvalid is 0.
  - Back-to-back reads produce back-to-back rvalid pulses, in issue order.
- Ordering (follows from RAM timing):
  - Write issued in cycle n, read of the same address issued in cycle n+1: the read returns the new data.
  - Read issued in cycle n, write issued in cycle n+1: the read returns the old data.
- Writes produce no response; gnt alone completes a write.
- rst asserted mid-operation:
  - In-flight reads are discarded; no rvalid is produced for them.
  - The RAM controls drop to 0 immediately.
  - The clear sweep restarts from address 0 when CLEAR_ON_RESET=1.

Test Plan:
- Clear sweep:
  - Stimulus: CLEAR_ON_RESET=1, CLEAR_VALUE=8'h00; release rst; hold a_req=1 throughout.
  - Required: busy high for exactly 256 cycles; ram_save high on addresses 0..255 in order; a_gnt=0 throughout CLEAR.
  - Required: first a_gnt on the cycle busy falls; a subsequent A read of address 8'h7F returns 8'h00.
- Single write then read:
  - Stimulus: A writes 8'h5A to 8'h10; the next cycle A reads 8'h10.
  - Required: a_rvalid pulses once, 2 edges after the read handshake, with a_rdata=8'h5A; b_rvalid stays 0.
- Contention:
  - Stimulus: both requesters hold req for 6 cycles, starting with pointer = A; A reads 8'h01, B reads 8'h02, with mem[1]=8'h11 and mem[2]=8'h22.
  - Required: grants alternate A, B, A, B, A, B.
  - Required: rvalid alternates a/b in the same order, with a_rdata=8'h11 and b_rdata=8'h22 on every pulse.
- Read/write hazard:
  - Setup: mem[8'h20]=8'h01.
  - Stimulus: A reads 8'h20 in cycle n while B writes 8'h02 to 8'h20 in cycle n+1.
  - Required: a_rdata=8'h01.
  - Follow-up: a further A read of 8'h20 returns 8'h02.
- Reset mid-read:
  - Stimulus: assert rst for 1 cycle, 1 cycle after an A read handshake.
  - Required: a_rvalid never pulses for that read; ram_load=0 while rst is high; busy=1 after rst is released.
- Back-to-back throughput:
  - Stimulus: A issues 4 consecutive reads to addresses 0..3, with mem[i] = 8'hA0+i.
  - Required: 4 consecutive a_rvalid pulses carrying 8'hA0, 8'hA1, 8'hA2, 8'hA3.
